// File: rtl/pwr_toggle_monitor_if.sv
// Observed shift-register outputs plus the counter read handshake of pwr_toggle_monitor.
interface pwr_toggle_monitor_if #(
    parameter int unsigned CNT_W = 32
);
    logic             ENB;
    logic [1:0]       MODO;
    logic [3:0]       Q;
    logic             S_OUT;
    logic             RD_REQ;
    logic [2:0]       RD_ADDR;
    logic             RD_ACK;
    logic [CNT_W-1:0] RD_DATA;
    logic             ARMED;

    modport master (
        output ENB, MODO, Q, S_OUT, RD_REQ, RD_ADDR,
        input  RD_ACK, RD_DATA, ARMED
    );

    modport slave (
        input  ENB, MODO, Q, S_OUT, RD_REQ, RD_ADDR,
        output RD_ACK, RD_DATA, ARMED
    );
endinterface

// File: rtl/pwr_toggle_monitor.sv
// Per-mode bit-toggle accumulators (dynamic-power proxy) for the 4-bit universal
// shift register, with saturating counters and a four-phase read port.
module pwr_toggle_monitor #(
    parameter int unsigned CNT_W     = 32,
    parameter bit          CLR_ON_RD = 1'b0
) (
    input  logic                CLK,
    input  logic                RESET,
    pwr_toggle_monitor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARM, COUNT} cnt_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_WAIT} rd_state_e;

    cnt_state_e       cstate_q, cstate_d;
    rd_state_e        rstate_q, rstate_d;
    logic [3:0]       q_prev_q, q_prev_d;
    logic             s_prev_q, s_prev_d;
    logic [CNT_W-1:0] cnt_q [5];
    logic [CNT_W-1:0] cnt_d [5];
    logic             rd_ack_q, rd_ack_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             armed_q, armed_d;
    logic [2:0]       toggles;
    logic [CNT_W-1:0] sel_cnt;
    logic             capture;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [2:0]       b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W+1)'(b);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    always_comb begin
        cstate_d  = cstate_q;
        rstate_d  = rstate_q;
        q_prev_d  = q_prev_q;
        s_prev_d  = s_prev_q;
        cnt_d     = cnt_q;
        rd_ack_d  = 1'b0;
        rd_data_d = rd_data_q;
        sel_cnt   = '0;
        capture   = (rstate_q == R_IDLE) && bus.RD_REQ;

        toggles = 3'(bus.S_OUT ^ s_prev_q);
        for (int unsigned i = 0; i < 4; i++) begin
            toggles = toggles + 3'(bus.Q[i] ^ q_prev_q[i]);
        end

        for (int unsigned i = 0; i < 5; i++) begin
            if (bus.RD_ADDR == 3'(i)) sel_cnt = cnt_q[i];
        end

        // Clear is applied first so a same-edge increment lands on zero and is kept.
        if (CLR_ON_RD && capture) begin
            for (int unsigned i = 0; i < 5; i++) begin
                if (bus.RD_ADDR == 3'(i)) cnt_d[i] = '0;
            end
        end

        case (cstate_q)
            IDLE: begin
                if (bus.ENB) cstate_d = ARM;
            end
            ARM: begin
                q_prev_d = bus.Q;
                s_prev_d = bus.S_OUT;
                cstate_d = bus.ENB ? COUNT : IDLE;
            end
            COUNT: begin
                if (bus.ENB) begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        if (bus.MODO == 2'(i)) cnt_d[i] = sat_add(cnt_d[i], toggles);
                    end
                    cnt_d[4] = sat_add(cnt_d[4], toggles);
                    q_prev_d = bus.Q;
                    s_prev_d = bus.S_OUT;
                end else begin
                    cstate_d = IDLE;
                end
            end
            default: cstate_d = IDLE;
        endcase
        armed_d = (cstate_d == COUNT);

        case (rstate_q)
            R_IDLE: begin
                if (bus.RD_REQ) begin
                    rstate_d  = R_ACK;
                    rd_ack_d  = 1'b1;
                    rd_data_d = sel_cnt;
                end
            end
            R_ACK:   rstate_d = R_WAIT;
            R_WAIT:  if (!bus.RD_REQ) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cstate_q  <= IDLE;
            rstate_q  <= R_IDLE;
            q_prev_q  <= '0;
            s_prev_q  <= 1'b0;
            cnt_q     <= '{default: '0};
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
            armed_q   <= 1'b0;
        end else begin
            cstate_q  <= cstate_d;
            rstate_q  <= rstate_d;
            q_prev_q  <= q_prev_d;
            s_prev_q  <= s_prev_d;
            cnt_q     <= cnt_d;
            rd_ack_q  <= rd_ack_d;
            rd_data_q <= rd_data_d;
            armed_q   <= armed_d;
        end
    end

    assign bus.RD_ACK  = rd_ack_q;
    assign bus.RD_DATA = rd_data_q;
    assign bus.ARMED   = armed_q;
endmodule

// File: tb/tb_pwr_toggle_monitor.sv
// Randomized bench for pwr_toggle_monitor: three instances (32-bit, 4-bit saturating,
// clear-on-read) share one stimulus and are checked against a run-length toggle model.
module tb_pwr_toggle_monitor;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enb = 1'b0;
    logic [1:0] modo = '0;
    logic [3:0] q = '0;
    logic       s = 1'b0;
    logic       rd_req = 1'b0;
    logic [2:0] rd_addr = '0;

    int     n_vec = 0;
    int     n_err = 0;
    longint m_cnt [5];
    longint c_cnt [5];
    longint exp_m, exp_c;
    int     run = 0;
    logic [3:0] m_qprev = '0;
    logic       m_sprev = 1'b0;

    always #5 clk = ~clk;

    pwr_toggle_monitor_if #(.CNT_W(32)) bif ();
    pwr_toggle_monitor_if #(.CNT_W(4))  bif_sat ();
    pwr_toggle_monitor_if #(.CNT_W(32)) bif_clr ();

    assign bif.ENB = enb;     assign bif.MODO = modo;     assign bif.Q = q;
    assign bif.S_OUT = s;     assign bif.RD_REQ = rd_req; assign bif.RD_ADDR = rd_addr;
    assign bif_sat.ENB = enb; assign bif_sat.MODO = modo; assign bif_sat.Q = q;
    assign bif_sat.S_OUT = s; assign bif_sat.RD_REQ = rd_req; assign bif_sat.RD_ADDR = rd_addr;
    assign bif_clr.ENB = enb; assign bif_clr.MODO = modo; assign bif_clr.Q = q;
    assign bif_clr.S_OUT = s; assign bif_clr.RD_REQ = rd_req; assign bif_clr.RD_ADDR = rd_addr;

    pwr_toggle_monitor #(.CNT_W(32), .CLR_ON_RD(1'b0)) dut (.CLK(clk), .RESET(rst), .bus(bif.slave));
    pwr_toggle_monitor #(.CNT_W(4), .CLR_ON_RD(1'b0)) dut_sat (.CLK(clk), .RESET(rst), .bus(bif_sat.slave));
    pwr_toggle_monitor #(.CNT_W(32), .CLR_ON_RD(1'b1)) dut_clr (.CLK(clk), .RESET(rst), .bus(bif_clr.slave));

    // Counting happens on the third and later consecutive enabled edges; toggles are
    // measured against the values seen on the previous edge.
    task automatic step(input bit cap);
        int t;
        if (rst) begin
            for (int i = 0; i < 5; i++) begin m_cnt[i] = 0; c_cnt[i] = 0; end
            run = 0; m_qprev = '0; m_sprev = 1'b0;
        end else begin
            run = enb ? ((run < 3) ? run + 1 : 3) : 0;
            t = $countones(q ^ m_qprev) + int'(s ^ m_sprev);
            if (cap) begin
                exp_m = (rd_addr < 3'd5) ? m_cnt[rd_addr] : 0;
                exp_c = (rd_addr < 3'd5) ? c_cnt[rd_addr] : 0;
                if (rd_addr < 3'd5) c_cnt[rd_addr] = 0;
            end
            if (enb && run >= 3) begin
                m_cnt[modo] += t; m_cnt[4] += t;
                c_cnt[modo] += t; c_cnt[4] += t;
            end
            if (enb) begin m_qprev = q; m_sprev = s; end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [2:0] a);
        logic [3:0] es;
        rd_addr = a; rd_req = 1'b1;
        step(1'b1);
        es = (exp_m > 15) ? 4'd15 : 4'(exp_m);
        n_vec += 6;
        if (bif.RD_ACK !== 1'b1) begin n_err++; $display("FAIL ack_main addr=%0d got=%b exp=1", a, bif.RD_ACK); end
        if (bif_sat.RD_ACK !== 1'b1) begin n_err++; $display("FAIL ack_sat addr=%0d got=%b exp=1", a, bif_sat.RD_ACK); end
        if (bif_clr.RD_ACK !== 1'b1) begin n_err++; $display("FAIL ack_clr addr=%0d got=%b exp=1", a, bif_clr.RD_ACK); end
        if (bif.RD_DATA !== 32'(exp_m)) begin n_err++; $display("FAIL data_main addr=%0d got=%0d exp=%0d", a, bif.RD_DATA, exp_m); end
        if (bif_sat.RD_DATA !== es) begin n_err++; $display("FAIL data_sat addr=%0d got=%0d exp=%0d", a, bif_sat.RD_DATA, es); end
        if (bif_clr.RD_DATA !== 32'(exp_c)) begin n_err++; $display("FAIL data_clr addr=%0d got=%0d exp=%0d", a, bif_clr.RD_DATA, exp_c); end
        rd_req = 1'b0;
        step(1'b0);
        n_vec += 2;
        if (bif.RD_ACK !== 1'b0 || bif_clr.RD_ACK !== 1'b0) begin
            n_err++; $display("FAIL ack_one_cycle addr=%0d got=%b/%b exp=0", a, bif.RD_ACK, bif_clr.RD_ACK);
        end
        if (bif.RD_DATA !== 32'(exp_m)) begin n_err++; $display("FAIL data_hold addr=%0d got=%0d exp=%0d", a, bif.RD_DATA, exp_m); end
        step(1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b0); step(1'b0);
        n_vec += 3;
        if ({bif.ARMED, bif_sat.ARMED, bif_clr.ARMED} !== 3'b000) begin
            n_err++; $display("FAIL reset_armed got=%b exp=000", {bif.ARMED, bif_sat.ARMED, bif_clr.ARMED});
        end
        if ({bif.RD_ACK, bif_sat.RD_ACK, bif_clr.RD_ACK} !== 3'b000) begin
            n_err++; $display("FAIL reset_ack got=%b exp=000", {bif.RD_ACK, bif_sat.RD_ACK, bif_clr.RD_ACK});
        end
        if (bif.RD_DATA !== 32'd0 || bif_clr.RD_DATA !== 32'd0 || bif_sat.RD_DATA !== 4'd0) begin
            n_err++; $display("FAIL reset_data got=%0d/%0d/%0d exp=0", bif.RD_DATA, bif_sat.RD_DATA, bif_clr.RD_DATA);
        end
        rst = 1'b0;
        for (int a = 0; a < 5; a++) do_read(3'(a));
    endtask

    task automatic test_load_hold();
        enb = 1'b1; modo = 2'd0; q = 4'b1101; s = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0);
            n_vec++;
            if (bif.ARMED !== (run >= 2)) begin
                n_err++; $display("FAIL load_armed edge=%0d got=%b exp=%b", i + 1, bif.ARMED, run >= 2);
            end
        end
        do_read(3'd0);
    endtask

    task automatic test_push();
        enb = 1'b0; step(1'b0);
        enb = 1'b1; modo = 2'd1; q = 4'b0000; s = 1'b1;
        step(1'b0); step(1'b0);
        q = 4'b0001; step(1'b0);
        q = 4'b0011; step(1'b0);
        q = 4'b0111; step(1'b0);
        q = 4'b1111; step(1'b0);
        for (int a = 0; a < 5; a++) do_read(3'(a));
    endtask

    task automatic test_cycle();
        enb = 1'b0; step(1'b0);
        enb = 1'b1; modo = 2'd2; q = 4'b1010; s = 1'b0;
        step(1'b0); step(1'b0);
        for (int i = 0; i < 4; i++) begin
            q = ~q; s = ~s;
            step(1'b0);
        end
        do_read(3'd2);
        do_read(3'd4);
    endtask

    task automatic test_clr_collision();
        modo = 2'd1;
        q = q ^ 4'b0001; step(1'b0);
        q = q ^ 4'b0001; step(1'b0);
        q = q ^ 4'b0111;
        do_read(3'd1);
        do_read(3'd1);
        do_read(3'd4);
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            enb = ($urandom_range(0, 9) != 0);
            modo = 2'($urandom); q = 4'($urandom); s = 1'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                do_read(3'($urandom_range(0, 7)));
            end else begin
                step(1'b0);
                n_vec++;
                if (bif.ARMED !== (run >= 2) || bif_clr.ARMED !== (run >= 2)) begin
                    n_err++; $display("FAIL rand_armed step=%0d got=%b exp=%b", i, bif.ARMED, run >= 2);
                end
            end
        end
    endtask

    task automatic test_reset_in_ack();
        rd_addr = 3'd2; rd_req = 1'b1;
        step(1'b1);
        rst = 1'b1; rd_req = 1'b0;
        step(1'b0);
        n_vec += 2;
        if ({bif.RD_ACK, bif_sat.RD_ACK, bif_clr.RD_ACK} !== 3'b000) begin
            n_err++; $display("FAIL rst_ack_ack got=%b exp=000", {bif.RD_ACK, bif_sat.RD_ACK, bif_clr.RD_ACK});
        end
        if (bif.RD_DATA !== 32'd0 || bif_clr.RD_DATA !== 32'd0 || bif_sat.RD_DATA !== 4'd0) begin
            n_err++; $display("FAIL rst_ack_data got=%0d/%0d/%0d exp=0", bif.RD_DATA, bif_sat.RD_DATA, bif_clr.RD_DATA);
        end
        rst = 1'b0; enb = 1'b0;
        step(1'b0);
        for (int a = 0; a < 5; a++) do_read(3'(a));
        do_read(3'd6);
    endtask

    task automatic test_rearm();
        enb = 1'b1; modo = 2'd3;
        for (int i = 0; i < 5; i++) begin q = 4'($urandom); s = 1'($urandom); step(1'b0); end
        enb = 1'b0; q = 4'($urandom); step(1'b0);
        enb = 1'b1; q = ~q; s = ~s; step(1'b0);
        q = ~q; step(1'b0);
        n_vec++;
        if (bif.ARMED !== 1'b1) begin n_err++; $display("FAIL rearm_armed got=%b exp=1", bif.ARMED); end
        do_read(3'd3);
        do_read(3'd4);
    endtask

    initial begin
        test_reset();
        test_load_hold();
        test_push();
        test_cycle();
        test_clr_collision();
        test_random();
        test_reset_in_ack();
        test_rearm();
        for (int a = 0; a < 8; a++) do_read(3'(a));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pwr_toggle_monitor.md
Name: pwr_toggle_monitor

Overview:
- Downstream consumer of the 4-bit universal shift register outputs (Q, S_OUT).
- Counts bit transitions per clock as a dynamic-power proxy and accumulates them into one counter per operating mode (MODO), plus a grand total.
- Exposes the counters through a four-phase read handshake, which the bench uses to dump the PwrCntr values at the end of a run.

Parameters:
- CNT_W, 32, width of every accumulator and of RD_DATA.
- CLR_ON_RD, 0, when 1 a completed read clears the addressed counter.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- ENB  input  1  count enable, same meaning as the shift register ENB.
- MODO  input  2  mode of the observed register; selects the counter to update.
- Q  input  4  observed register parallel output.
- S_OUT  input  1  observed register serial output.
- RD_REQ  input  1  read request, level, held until RD_ACK.
- RD_ADDR  input  3  counter select: 0..3 per-MODO counters, 4 total, 5..7 reserved.
- RD_ACK  output  1  one-cycle read acknowledge.
- RD_DATA  output  CNT_W  read data, valid while RD_ACK=1 and held until the next read.
- ARMED  output  1  high while the block is in COUNT.

Behaviour:
- Reset (RESET=1 at a CLK edge):
  - All counters become 0.
  - Q_prev and S_prev become 0.
  - Count FSM goes to IDLE and read FSM to R_IDLE.
  - RD_ACK=0, RD_DATA=0, ARMED=0.
  - Reset overrides everything, including an in-flight read; no ACK is issued for it.
- Count FSM:
  - IDLE, with ENB=0: no counting. ENB=1 -> ARM.
  - ARM: captures Q_prev<=Q and S_prev<=S_OUT; no counting. ENB=1 -> COUNT; ENB=0 -> IDLE.
  - COUNT: each edge computes t = popcount(Q^Q_prev) + (S_OUT^S_prev), range 0..5.
    - CNT[MODO] += t and TOTAL += t.
    - Q_prev and S_prev are updated.
    - ENB=0 -> IDLE without counting that edge.
  - The first enabled cycle after IDLE never counts. This prevents spurious toggles from stale prev values.
- Arithmetic:
  - t is zero-extended to CNT_W.
  - Each counter saturates independently at 2^CNT_W-1 and never wraps.
  - Counters are unchanged when t=0.
- Read FSM:
  - R_IDLE: RD_REQ=1 -> R_ACK. At that edge RD_DATA <= addressed counter (pre-update value of the current cycle); addresses 5..7 return 0.
  - R_ACK: RD_ACK=1 for exactly one cycle, then -> R_WAIT.
  - R_WAIT: waits for RD_REQ=0, then -> R_IDLE. A new read needs RD_REQ low for at least one edge.
  - Latency: RD_REQ high at edge N gives RD_ACK high during cycle N+1.
- Read runs concurrently with counting. Reads are legal while ENB=0.
- CLR_ON_RD=1 with same-edge collision: when the capture edge (R_IDLE->R_ACK) coincides with an increment to the same counter, the counter becomes t. Clear takes priority, but the current toggles are not lost.
  - Reading address 4 clears TOTAL only.
  - Reserved addresses clear nothing.
- CLR_ON_RD=0: reads are non-destructive.
- MODO changing in COUNT: toggles at that edge go to the counter of the MODO value sampled at that same edge.

Test Plan:
- Reset, then ENB=1, MODO=0 (LOAD), Q held 4'b1101, S_OUT=0 for 6 cycles -> ARMED=1 from the 2nd edge; read addr 0 returns 0; RD_ACK high exactly one cycle after the RD_REQ edge.
- MODO=1 (PUSH), Q sequence 0000->0001->0011->0111->1111, S_OUT constant -> CNT[1]=4 and TOTAL=4; CNT[0], CNT[2] and CNT[3] read 0.
- MODO=2 (CYCLE), Q alternating 1010/0101 and S_OUT toggling each cycle for 4 counted edges -> CNT[2]=20, TOTAL=20 + prior.
- CNT_W=4, drive 5 toggles per cycle for 4 cycles -> counter reads 15 (saturated, no wrap).
- CLR_ON_RD=1: read addr 1 on the same edge as a 3-toggle update in MODO=1 -> RD_DATA = old value; a subsequent read returns 3.
- RESET asserted in R_ACK -> RD_ACK=0 the next cycle and all counters read 0; a read of addr 6 returns 0; ENB dropped for 1 cycle then raised -> the re-arm edge adds nothing.
